instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/instruction_fetch_two_word_decode.sv | 24 ++
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: machine-cycle phase codes, two-word opcode
// groups and the fetch sequencer state encoding. The PC stack imports
// the same phase constants so both blocks agree on cycle numbering.
package instruction_fetch_pkg;

  // Eight phases of one instruction cycle
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;  // ROM drives OPR
  localparam logic [2:0] PH_M2 = 3'd4;  // ROM drives OPA
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // OPR codes whose instruction carries a second ROM word
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;  // FIM when OPA[0]==0, SRC otherwise
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  // Fetch sequencer states
  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

endpackage

// File: rtl/instruction_fetch_two_word_decode.sv
// Decides whether a first instruction word is followed by a second word.
module two_word_decode
  import instruction_fetch_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  output logic       is_two_word
);

  // Only OPA bit 0 matters (FIM vs SRC); the upper bits are don't-care
  logic unused_opa_hi;
  assign unused_opa_hi = ^opa[3:1];

  // Opcode-group match
  always_comb begin
    is_two_word = 1'b0;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: is_two_word = 1'b1;
      OPR_FIM_SRC:                        is_two_word = ~opa[0];
      default:                            is_two_word = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: 8-phase cycle sequencer, ROM nibble capture and
// one/two-word instruction assembly. PC nibbles pass straight to the bus.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int CYCLE_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_hold,
  input  logic [3:0]         data_in,
  input  logic               pc_enable,
  input  logic [3:0]         pc_word,
  output logic [CYCLE_W-1:0] cycle,
  output logic               sync,
  output logic [3:0]         bus_out,
  output logic               bus_oe,
  output logic [3:0]         inst_opr,
  output logic [3:0]         inst_opa,
  output logic [7:0]         inst_operand,
  output logic               inst_valid,
  output logic               second_word
);

  logic [0:0] state;
  logic [3:0] opr_q, opa_q;
  logic       at_m1, at_m2, at_x3;
  logic [3:0] dec_opa;
  logic       is_two;

  assign at_m1 = (cycle == CYCLE_W'(PH_M1));
  assign at_m2 = (cycle == CYCLE_W'(PH_M2));
  assign at_x3 = (cycle == CYCLE_W'(PH_X3));

  assign sync        = at_x3;
  assign second_word = (state == ST_SECOND);

  // PC stack drives the bus directly, no register stage
  assign bus_oe  = pc_enable;
  assign bus_out = pc_enable ? pc_word : 4'h0;

  // At M2 the OPA nibble is still on the bus; later the latched copy is used
  assign dec_opa = at_m2 ? data_in : opa_q;

  two_word_decode u_dec (
    .opr         (opr_q),
    .opa         (dec_opa),
    .is_two_word (is_two)
  );

  // Phase counter: wraps after X3, parks at X3 while fetch_hold is high
  always_ff @(posedge clock) begin
    if (reset)         cycle <= '0;
    else if (at_x3)    cycle <= fetch_hold ? cycle : '0;
    else               cycle <= cycle + 1'b1;
  end

  // Raw ROM nibble latches
  always_ff @(posedge clock) begin
    if (reset) begin
      opr_q <= 4'h0;
      opa_q <= 4'h0;
    end else begin
      if (at_m1) opr_q <= data_in;
      if (at_m2) opa_q <= data_in;
    end
  end

  // Instruction assembly; inst_valid is a single-clock pulse in X1
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_opr     <= 4'h0;
      inst_opa     <= 4'h0;
      inst_operand <= 8'h00;
      inst_valid   <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      if (at_m2) begin
        if (state == ST_FIRST) begin
          inst_opr <= opr_q;
          inst_opa <= data_in;
          if (!is_two) begin
            inst_operand <= 8'h00;
            inst_valid   <= 1'b1;
          end
        end else begin
          inst_operand <= {opr_q, data_in};
          inst_valid   <= 1'b1;
        end
      end
    end
  end

  // Word sequencer; the second word is never decoded, it always returns to FIRST
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FIRST;
    end else if (at_x3 && !fetch_hold) begin
      if (state == ST_FIRST) state <= is_two ? ST_SECOND : ST_FIRST;
      else                   state <= ST_FIRST;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a cycle/state model tracks the
// sequencer, expected instructions are queued as ROM words are driven and
// popped whenever inst_valid fires.
module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetch_hold;
  logic [3:0] data_in;
  logic       pc_enable;
  logic [3:0] pc_word;
  logic [2:0] cycle;
  logic       sync;
  logic [3:0] bus_out;
  logic       bus_oe;
  logic [3:0] inst_opr, inst_opa;
  logic [7:0] inst_operand;
  logic       inst_valid;
  logic       second_word;

  instruction_fetch #(.CYCLE_W(3)) dut (
    .clock(clock), .reset(reset), .fetch_hold(fetch_hold), .data_in(data_in),
    .pc_enable(pc_enable), .pc_word(pc_word), .cycle(cycle), .sync(sync),
    .bus_out(bus_out), .bus_oe(bus_oe), .inst_opr(inst_opr), .inst_opa(inst_opa),
    .inst_operand(inst_operand), .inst_valid(inst_valid), .second_word(second_word)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model state
  int          mcyc   = 0;
  bit          mstate = 0;
  bit          pend   = 0;
  bit          vexp   = 0;
  logic [3:0]  mopr, mopa;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is2(input logic [3:0] r, input logic [3:0] a);
    case (r)
      4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
      4'h2:                   return ~a[0];
      default:                return 1'b0;
    endcase
  endfunction

  // advance one clock, update the model, compare every observable
  task automatic tick();
    logic [15:0] e;
    @(posedge clock);
    #1;
    if (mcyc == 5) vexp = 0;
    if (reset) begin
      mcyc = 0; mstate = 0; pend = 0; vexp = 0;
    end else if (mcyc == 7) begin
      if (!fetch_hold) begin
        mcyc   = 0;
        mstate = mstate ? 1'b0 : pend;
        pend   = 0;
      end
    end else begin
      mcyc++;
    end
    chk("cycle", 32'(cycle), 32'(mcyc));
    chk("sync", 32'(sync), 32'(mcyc == 7));
    chk("second_word", 32'(second_word), 32'(mstate));
    chk("valid", 32'(inst_valid), 32'(vexp && mcyc == 5));
    if (inst_valid) begin
      if (q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
      else begin
        e = q.pop_front();
        chk("instr", 32'({inst_opr, inst_opa, inst_operand}), 32'(e));
      end
    end
  endtask

  // drive one ROM word over a full instruction cycle starting at cycle 0
  task automatic fetch(input logic [3:0] r, input logic [3:0] a, input int hold_n);
    logic [15:0] snap;
    for (int c = 0; c < 8; c++) begin
      data_in = (c == 3) ? r : (c == 4) ? a : 4'($urandom);
      if (c == 4) begin
        if (!mstate) begin
          mopr = r; mopa = a;
          if (is2(r, a)) pend = 1;
          else begin q.push_back({r, a, 8'h00}); vexp = 1; end
        end else begin
          q.push_back({mopr, mopa, r, a});
          vexp = 1;
        end
      end
      if (c == 7 && hold_n > 0) begin
        fetch_hold = 1'b1;
        snap = {inst_opr, inst_opa, inst_operand};
        repeat (hold_n) begin
          tick();
          chk("hold_instr", 32'({inst_opr, inst_opa, inst_operand}), 32'(snap));
        end
        fetch_hold = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fetch_hold = 1'b0; data_in = 4'h0; pc_enable = 1'b0; pc_word = 4'h9;
    tick(); tick();
    chk("rst_instr", 32'({inst_opr, inst_opa, inst_operand}), 32'(0));
    #1;
    chk("bus_idle", 32'({bus_oe, bus_out}), 32'(0));
    reset = 1'b0;

    // free run: two plain one-word instructions
    fetch(4'h0, 4'h0, 0);
    fetch(4'h0, 4'h0, 0);
    // LDM 5
    fetch(4'hD, 4'h5, 0);
    // JUN 0x123
    fetch(4'h4, 4'h1, 0);
    fetch(4'h2, 4'h3, 0);
    // FIM (two-word), then SRC (one-word)
    fetch(4'h2, 4'h4, 0);
    fetch(4'h6, 4'h7, 0);
    fetch(4'h2, 4'h5, 0);
    // hold at X3 for 5 clocks
    fetch(4'hA, 4'hB, 5);
    // second word with a hold: state must not advance early
    fetch(4'h7, 4'h2, 2);
    fetch(4'h1, 4'hF, 3);
    // random mix
    for (int i = 0; i < 8; i++) fetch(4'($urandom), 4'($urandom), i % 3);
    // drain any dangling first word into a plain instruction
    if (mstate) fetch(4'h3, 4'h3, 0);

    // JMS first word, then reset at cycle 2 of the second-word fetch
    fetch(4'h5, 4'h0, 0);
    for (int c = 0; c < 2; c++) begin data_in = 4'($urandom); tick(); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_instr", 32'({inst_opr, inst_opa, inst_operand, inst_valid}), 32'(0));
    pc_enable = 1'b1; pc_word = 4'h9;
    #1;
    chk("bus_drive", 32'({bus_oe, bus_out}), 32'({1'b1, 4'h9}));
    pc_word = 4'h6;
    #1;
    chk("bus_follow", 32'({bus_oe, bus_out}), 32'({1'b1, 4'h6}));
    pc_enable = 1'b0;
    #1;
    chk("bus_off", 32'({bus_oe, bus_out}), 32'(0));
    fetch(4'hC, 4'h3, 0);

    chk("sb_drained", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
